// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - funct3 access-size encodings (RV32I loads/stores)
//   - exception cause codes reported to the CSR/trap logic
//   - FSM state type
//   - misalignment helper
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    // Halfword needs addr[0]==0; word needs addr[1:0]==00. Byte never faults.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (f3[1]) begin
            mis = (off != 2'b00);
        end else if (f3[0]) begin
            mis = off[0];
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
// Store side: st_funct3/st_off/st_data -> st_wmask (lane enables), st_wdata
//             (data replicated across lanes).
// Load side:  ld_funct3/ld_off/ld_word -> ld_data (selected byte/halfword,
//             sign- or zero-extended; words pass through).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_wmask,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wmask = 4'b1111;
        st_wdata = st_data;
        case (st_funct3)
            F3_B: begin
                st_wmask = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_H: begin
                st_wmask = 4'b0011 << st_off;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_wmask = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_word[{ld_off, 3'b000} +: 8];
        ld_half = ld_word[{ld_off[1], 4'b0000} +: 16];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'h000000, ld_byte};
            F3_HU:   ld_data = {16'h0000, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit for the 3-stage RV32I pipeline.
// Takes the MW-stage op (mem_read/mem_write, funct3, ALUResult_MW address,
// rdata2_MW store data, waddr_MW destination), runs one req/ack transaction
// on the dmem_* port, stalls the pipeline (lsu_stall) while it is outstanding,
// and returns extended load data on lsu_valid/lsu_rdata/lsu_waddr.
// Misaligned accesses and accesses with no ack within TIMEOUT_CYCLES are
// reported on lsu_exc/lsu_exc_cause/lsu_exc_tval. flush suppresses the
// result pulse of the current op without cancelling a bus transaction.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult_MW,
    input  logic [31:0] rdata2_MW,
    input  logic [4:0]  waddr_MW,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        lsu_stall,
    output logic        lsu_valid,
    output logic [31:0] lsu_rdata,
    output logic [4:0]  lsu_waddr,
    output logic        lsu_exc,
    output logic [3:0]  lsu_exc_cause,
    output logic [31:0] lsu_exc_tval
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  req_waddr_q, req_waddr_d;
    logic        is_load_q, is_load_d;
    logic        load_ok_q, load_ok_d;
    logic        exc_pend_q, exc_pend_d;
    logic        flushed_q, flushed_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] tval_q, tval_d;

    logic        op_present;
    logic [3:0]  st_wmask;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign op_present = mem_read | mem_write;

    // Store lanes come from the live MW inputs; load extraction uses the
    // size/offset latched at issue, since the word arrives cycles later.
    lsu_align u_align (
        .st_funct3 (funct3),
        .st_off    (ALUResult_MW[1:0]),
        .st_data   (rdata2_MW),
        .st_wmask  (st_wmask),
        .st_wdata  (st_wdata),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .ld_word   (dmem_rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        f3_d        = f3_q;
        off_d       = off_q;
        req_waddr_d = req_waddr_q;
        is_load_d   = is_load_q;
        load_ok_d   = load_ok_q;
        exc_pend_d  = exc_pend_q;
        flushed_d   = flushed_q;
        rdata_d     = rdata_q;
        waddr_d     = waddr_q;
        cause_d     = cause_q;
        tval_d      = tval_q;

        case (state_q)
            S_IDLE: begin
                if (op_present && !flush) begin
                    f3_d        = funct3;
                    off_d       = ALUResult_MW[1:0];
                    req_waddr_d = waddr_MW;
                    is_load_d   = mem_read;
                    load_ok_d   = 1'b0;
                    flushed_d   = 1'b0;
                    cnt_d       = '0;
                    if (is_misaligned(funct3, ALUResult_MW[1:0])) begin
                        exc_pend_d = 1'b1;
                        cause_d    = mem_read ? CAUSE_LOAD_MISALIGNED : CAUSE_STORE_MISALIGNED;
                        tval_d     = ALUResult_MW;
                        state_d    = S_DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = {ALUResult_MW[31:2], 2'b00};
                        wmask_d = mem_write ? st_wmask : 4'b0000;
                        if (mem_write) begin
                            wdata_d = st_wdata;
                        end
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                // Ack takes priority over a timeout landing in the same cycle.
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    if (is_load_q) begin
                        rdata_d   = ld_data;
                        waddr_d   = req_waddr_q;
                        load_ok_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d      = 1'b0;
                    exc_pend_d = 1'b1;
                    cause_d    = is_load_q ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
                    tval_d     = {addr_q[31:2], off_q};
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                cnt_d      = '0;
                load_ok_d  = 1'b0;
                exc_pend_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            req_waddr_q <= '0;
            is_load_q   <= 1'b0;
            load_ok_q   <= 1'b0;
            exc_pend_q  <= 1'b0;
            flushed_q   <= 1'b0;
            rdata_q     <= '0;
            waddr_q     <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            req_waddr_q <= req_waddr_d;
            is_load_q   <= is_load_d;
            load_ok_q   <= load_ok_d;
            exc_pend_q  <= exc_pend_d;
            flushed_q   <= flushed_d;
            rdata_q     <= rdata_d;
            waddr_q     <= waddr_d;
            cause_q     <= cause_d;
            tval_q      <= tval_d;
        end
    end

    // A flush arriving in DONE itself still suppresses the pulse, so the
    // pulses are gated with the live flush input.
    assign lsu_stall     = (state_q == S_BUSY) || ((state_q == S_IDLE) && op_present && !flush);
    assign lsu_valid     = (state_q == S_DONE) && load_ok_q && !flushed_q && !flush;
    assign lsu_exc       = (state_q == S_DONE) && exc_pend_q && !flushed_q && !flush;
    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign dmem_wmask    = wmask_q;
    assign lsu_rdata     = rdata_q;
    assign lsu_waddr     = waddr_q;
    assign lsu_exc_cause = cause_q;
    assign lsu_exc_tval  = tval_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] ALUResult_MW, rdata2_MW;
    logic [4:0]  waddr_MW;
    logic        flush;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        lsu_stall, lsu_valid, lsu_exc;
    logic [31:0] lsu_rdata, lsu_exc_tval;
    logic [4:0]  lsu_waddr;
    logic [3:0]  lsu_exc_cause;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_exc;
        logic [31:0] data;
        logic [4:0]  waddr;
        logic [3:0]  cause;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .funct3        (funct3),
        .ALUResult_MW  (ALUResult_MW),
        .rdata2_MW     (rdata2_MW),
        .waddr_MW      (waddr_MW),
        .flush         (flush),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_wmask    (dmem_wmask),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .lsu_stall     (lsu_stall),
        .lsu_valid     (lsu_valid),
        .lsu_rdata     (lsu_rdata),
        .lsu_waddr     (lsu_waddr),
        .lsu_exc       (lsu_exc),
        .lsu_exc_cause (lsu_exc_cause),
        .lsu_exc_tval  (lsu_exc_tval)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic push_valid(input logic [31:0] d, input logic [4:0] wa);
        exp_t e;
        e.is_exc = 1'b0; e.data = d; e.waddr = wa; e.cause = '0;
        sb.push_back(e);
    endtask

    task automatic push_exc(input logic [3:0] c, input logic [31:0] tval);
        exp_t e;
        e.is_exc = 1'b1; e.data = tval; e.waddr = '0; e.cause = c;
        sb.push_back(e);
    endtask

    // Monitor: every result/exception pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && (lsu_valid || lsu_exc)) begin
            exp_t e;
            if (lsu_valid && lsu_exc) begin
                chk("valid_exc_overlap", 32'(lsu_exc), 32'd0);
            end else if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'b0, lsu_exc, lsu_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                if (lsu_valid) begin
                    chk("pulse_kind_valid", 32'(e.is_exc), 32'd0);
                    chk("lsu_rdata", lsu_rdata, e.data);
                    chk("lsu_waddr", 32'(lsu_waddr), 32'(e.waddr));
                end else begin
                    chk("pulse_kind_exc", 32'(e.is_exc), 32'd1);
                    chk("lsu_exc_cause", 32'(lsu_exc_cause), 32'(e.cause));
                    chk("lsu_exc_tval", lsu_exc_tval, e.data);
                end
            end
        end
    end

    // One MW-stage op. ack_delay = wait cycles before ack (-1: never acked).
    // flush_cyc = cycle in which flush is pulsed (-1: none).
    task automatic run_op(input string nm, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] wa, input int ack_delay, input logic [31:0] rword,
                          input int flush_cyc, input int exp_done, input int exp_req,
                          input logic [31:0] exp_addr, input logic [3:0] exp_wmask,
                          input logic [31:0] exp_wdata);
        int reqs = 0;
        int stalls = 0;
        int done = -1;
        bit seen = 0;
        logic [31:0] c_addr = '0, c_wdata = '0;
        logic [3:0]  c_wmask = '0;
        logic        c_we = 1'b0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; ALUResult_MW = a;
        rdata2_MW = d; waddr_MW = wa; dmem_rdata = rword; dmem_ack = 1'b0;
        flush = (flush_cyc == 0);
        for (int c = 0; c < 40 && done < 0; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                flush = (c == flush_cyc);
                dmem_ack = dmem_req && (ack_delay >= 0) && (reqs == ack_delay);
            end
            @(negedge clk);
            if (lsu_stall) stalls++;
            if (dmem_req) begin
                if (!seen) begin
                    c_addr = dmem_addr; c_wdata = dmem_wdata;
                    c_wmask = dmem_wmask; c_we = dmem_we;
                end
                seen = 1;
                reqs++;
            end
            if (!lsu_stall && c > 0) done = c;
        end
        if (done < 0) begin
            chk({nm, "_completion_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, "_done_cycle"}, 32'(done), 32'(exp_done));
            chk({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_done));
            chk({nm, "_req_cycles"}, 32'(reqs), 32'(exp_req));
            if (exp_req > 0) begin
                chk({nm, "_dmem_addr"}, c_addr, exp_addr);
                chk({nm, "_dmem_we"}, 32'(c_we), 32'(wr));
                chk({nm, "_dmem_wmask"}, 32'(c_wmask), 32'(exp_wmask));
                if (wr) chk({nm, "_dmem_wdata"}, c_wdata, exp_wdata);
            end
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        ALUResult_MW = '0; rdata2_MW = '0; waddr_MW = '0; flush = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_dmem_req", 32'(dmem_req), 32'd0);
        chk("reset_dmem_wmask", 32'(dmem_wmask), 32'd0);
        chk("reset_dmem_addr", dmem_addr, 32'd0);
        chk("reset_lsu_rdata", lsu_rdata, 32'd0);
        chk("reset_lsu_stall", 32'(lsu_stall), 32'd0);

        // LW, ack in the first request cycle
        push_valid(32'hDEADBEEF, 5'd5);
        run_op("lw_fast", 1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, -1,
               2, 1, 32'h100, 4'b0000, 32'h0);
        // LB, 3 wait cycles: ack lands exactly on the timeout cycle and wins
        push_valid(32'hFFFFFF80, 5'd7);
        run_op("lb_wait3", 1, 0, 3'b000, 32'h203, 32'h0, 5'd7, 3, 32'h80000000, -1,
               5, 4, 32'h200, 4'b0000, 32'h0);
        push_valid(32'h00000080, 5'd8);
        run_op("lbu", 1, 0, 3'b100, 32'h203, 32'h0, 5'd8, 0, 32'h80000000, -1,
               2, 1, 32'h200, 4'b0000, 32'h0);
        push_valid(32'hFFFF8001, 5'd9);
        run_op("lh_hi", 1, 0, 3'b001, 32'h106, 32'h0, 5'd9, 2, 32'h80017FFF, -1,
               4, 3, 32'h104, 4'b0000, 32'h0);
        push_valid(32'h00008001, 5'd10);
        run_op("lhu_hi", 1, 0, 3'b101, 32'h106, 32'h0, 5'd10, 0, 32'h80017FFF, -1,
               2, 1, 32'h104, 4'b0000, 32'h0);
        // Stores: no lsu_valid expected
        run_op("sh", 0, 1, 3'b001, 32'h302, 32'h0000ABCD, 5'd0, 1, 32'h0, -1,
               3, 2, 32'h300, 4'b1100, 32'hABCDABCD);
        run_op("sb", 0, 1, 3'b000, 32'h401, 32'h000000AB, 5'd0, 0, 32'h0, -1,
               2, 1, 32'h400, 4'b0010, 32'hABABABAB);
        // Misaligned: no request, exception at cycle 1
        push_exc(4'd4, 32'h1002);
        run_op("lw_mis", 1, 0, 3'b010, 32'h1002, 32'h0, 5'd3, 0, 32'h0, -1,
               1, 0, 32'h0, 4'b0000, 32'h0);
        push_exc(4'd6, 32'h303);
        run_op("sh_mis", 0, 1, 3'b001, 32'h303, 32'h1234, 5'd0, 0, 32'h0, -1,
               1, 0, 32'h0, 4'b0000, 32'h0);
        // SW never acked: 4 request cycles then store fault
        push_exc(4'd7, 32'h500);
        run_op("sw_timeout", 0, 1, 3'b010, 32'h500, 32'h12345678, 5'd0, -1, 32'h0, -1,
               5, 4, 32'h500, 4'b1111, 32'h12345678);
        // Flush during BUSY: transaction completes, result suppressed
        run_op("lw_flush", 1, 0, 3'b010, 32'h700, 32'h0, 5'd4, 1, 32'hCAFEF00D, 1,
               3, 2, 32'h700, 4'b0000, 32'h0);

        // Reset mid-BUSY, then a late ack in IDLE must be ignored
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b010; ALUResult_MW = 32'h600; waddr_MW = 5'd3;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstbusy_req_before", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0; dmem_ack = 1'b1;
        @(negedge clk);
        chk("rstbusy_dmem_req", 32'(dmem_req), 32'd0);
        chk("rstbusy_dmem_we", 32'(dmem_we), 32'd0);
        chk("rstbusy_dmem_wmask", 32'(dmem_wmask), 32'd0);
        chk("rstbusy_dmem_addr", dmem_addr, 32'd0);
        chk("rstbusy_dmem_wdata", dmem_wdata, 32'd0);
        chk("rstbusy_lsu_rdata", lsu_rdata, 32'd0);
        chk("rstbusy_lsu_waddr", 32'(lsu_waddr), 32'd0);
        chk("rstbusy_exc_cause", 32'(lsu_exc_cause), 32'd0);
        chk("rstbusy_exc_tval", lsu_exc_tval, 32'd0);
        chk("rstbusy_stall", 32'(lsu_stall), 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        chk("late_ack_stall", 32'(lsu_stall), 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: simulation did not finish, errors %0d", errors);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the 3-stage RV32I pipeline. It consumes the memory/writeback pipeline register outputs (address from the ALU result, store data, destination register) and runs a req/ack transaction with data memory. It stalls the memory/writeback register while the access is outstanding, then returns the extended load data. Misaligned and timed-out accesses are reported to the CSR/trap logic.

## Interface
- TIMEOUT_CYCLES, 255: maximum BUSY cycles without ack before an access fault is raised; range 1..65535.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  MW-stage op is a load.
- mem_write  in  1  MW-stage op is a store; never high together with mem_read.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use 000/001/010 only.
- ALUResult_MW  in  32  effective byte address.
- rdata2_MW  in  32  store data, in the low bits.
- waddr_MW  in  5  load destination register.
- flush  in  1  trap taken; suppresses the current op's result.
- dmem_req  out  1  request valid; held until ack.
- dmem_we  out  1  store when 1.
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- dmem_wdata  out  32  store data replicated across lanes.
- dmem_wmask  out  4  byte-lane enables; 0000 for loads.
- dmem_ack  in  1  completion; rdata valid in the same cycle.
- dmem_rdata  in  32  raw read word.
- lsu_stall  out  1  holds the MW register and everything upstream.
- lsu_valid  out  1  one-cycle pulse: load result ready for writeback.
- lsu_rdata  out  32  extended load data.
- lsu_waddr  out  5  destination register paired with lsu_valid.
- lsu_exc  out  1  one-cycle exception pulse.
- lsu_exc_cause  out  4  4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault.
- lsu_exc_tval  out  32  faulting byte address.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, no op: all outputs idle.
- IDLE, op present and flush=0:
  - lsu_stall=1 combinationally.
  - Aligned op: next state BUSY. Request fields are latched: addr, we, wmask, wdata, funct3, addr[1:0], waddr.
  - Misaligned op: next state DONE with the exception latched; no request is issued. Misaligned means H with addr[0]=1, or W with addr[1:0]≠00.
- IDLE, op present and flush=1: no issue; stays IDLE.
- BUSY:
  - dmem_req=1 from the registered request; lsu_stall=1; timeout counter increments.
  - dmem_ack=1: capture the extended rdata; next state DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: latch fault cause 5 or 7; next state DONE; dmem_req drops.
- DONE:
  - lsu_stall=0, so the MW register advances at this edge.
  - lsu_valid=1 for a successful load, unless flush was seen during BUSY or DONE.
  - lsu_exc=1 for an exception, unless flushed.
  - Next state IDLE; the counter clears.
- Store lanes:
  - SB: mask = 0001<<addr[1:0], wdata = {4{b}}.
  - SH: mask = 0011<<addr[1:0], wdata = {2{h}}.
  - SW: mask = 1111.
- Load extraction:
  - The byte or halfword is selected by the latched addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Outputs hold their last value when not valid, except the pulses, which are 0.

## Timing
- Reset values:
  - State IDLE; counter 0.
  - dmem_req, dmem_we, lsu_valid, lsu_exc = 0.
  - dmem_wmask = 0000.
  - dmem_addr, dmem_wdata, lsu_rdata, lsu_exc_tval = 0.
  - lsu_waddr = 0; lsu_exc_cause = 0.
- lsu_stall is combinational and not forced by reset beyond the IDLE state.
- Best case: op at cycle 0, dmem_req at cycle 1, ack at cycle 1, lsu_valid at cycle 2. Stall is high in cycles 0–1.
- Each ack-wait cycle adds one cycle.
- Misaligned op: exception pulse at cycle 1; stall high in cycle 0 only.
- Timeout: req high for TIMEOUT_CYCLES cycles (1..TIMEOUT_CYCLES); fault pulse in the next cycle.
- Ack in the same cycle the timeout is reached: ack wins and no fault is raised.
- A request is never withdrawn before ack or timeout, except by rst.
- flush during BUSY does not cancel the bus transaction; it only suppresses the result.
- rst mid-BUSY: dmem_req is 0 in the next cycle, and a late ack in IDLE is ignored.

## Structure
- lsu_pkg:
  - funct3 size encodings.
  - cause constants 4/5/6/7.
  - state enum typedef.
- Sub-module lsu_align: combinational lane logic producing wmask/wdata and load extract/extend. Pure function of funct3, addr[1:0] and data.
- Counter width: $clog2(TIMEOUT_CYCLES+1).

## Test plan
- LW at 0x100, ack same cycle as req, rdata 0xDEADBEEF:
  - lsu_valid at cycle 2 with lsu_rdata 0xDEADBEEF and lsu_waddr echoed.
  - stall high for exactly 2 cycles.
- LB at 0x203, rdata 0x80000000, ack after 3 waits → 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x302, data 0x0000ABCD → dmem_we=1, wmask 1100, wdata 0xABCDABCD, dmem_addr 0x300; no lsu_valid.
- LW at 0x1002 → no dmem_req ever; lsu_exc pulse with cause 4 and tval 0x1002 at cycle 1.
- SW, ack never returned, TIMEOUT_CYCLES=4 → req high for 4 cycles; cause 7 pulse; stall released.
- rst asserted in BUSY → dmem_req=0 next cycle and all outputs at reset values. A flush asserted in BUSY instead → ack is consumed with no lsu_valid.
